// File: rtl/s2f_xfer_arbiter.sv
// Round-robin arbiter sharing one toggle-based slow-to-fast crossing channel.
// Launches a held payload with a toggle flip and waits for the synchronised echo.
module s2f_xfer_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int ACK_TIMEOUT = 15,
  localparam int IW         = $clog2(NREQ)
) (
  input  logic               clk1,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               xfer_tog,
  output logic [DW-1:0]      xfer_data,
  output logic [IW-1:0]      xfer_id,
  input  logic               ack_tog,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;
  logic              r_tog;
  logic [DW-1:0]     r_data;
  logic [IW-1:0]     r_id;
  logic [NREQ-1:0]   r_gnt;
  logic              r_err;

  state_t            w_state_n;
  logic [2*NREQ-1:0] w_dbl;
  logic [IW:0]       w_sum;
  logic              w_any;
  logic [IW-1:0]     w_sel;
  logic [IW-1:0]     w_ptr_n;
  logic [DW-1:0]     w_pay;
  logic              w_done;
  logic              w_launch;
  logic              w_timeout;

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  assign w_dbl = {req, req} >> r_ptr;

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_dbl[k] && !w_any) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_ptr} + (IW+1)'(k);
        if (w_sum >= (IW+1)'(NREQ)) begin
          w_sum = w_sum - (IW+1)'(NREQ);
        end
        w_sel = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_pay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == IW'(i)) begin
        w_pay = req_data[i*DW +: DW];
      end
    end
  end

  assign w_ptr_n = (w_sel == IW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_done  = (ack_tog == r_tog);

  // Completion is tested before timeout so a same-cycle echo wins.
  always_comb begin
    w_state_n = r_state;
    w_launch  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_launch  = 1'b1;
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done) begin
          w_state_n = S_IDLE;
        end else if (ACK_TIMEOUT != 0 && r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_state_n = S_ERR;
        end
      end
      S_ERR: begin
        if (w_done) begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_tog   <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= '0;
      if (w_launch) begin
        r_tog  <= ~r_tog;
        r_data <= w_pay;
        r_id   <= w_sel;
        r_gnt  <= NREQ'(1) << w_sel;
        r_ptr  <= w_ptr_n;
        r_cnt  <= '0;
      end else if (r_state == S_WAIT && !w_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign xfer_tog  = r_tog;
  assign xfer_data = r_data;
  assign xfer_id   = r_id;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_s2f_xfer_arbiter.sv
// Bench for s2f_xfer_arbiter: directed scenarios, per-cycle model compare,
// and literal spot checks on grant order, latency and error handling.
module tb_s2f_xfer_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 15;

  logic        clk1 = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        xfer_tog;
  logic [7:0]  xfer_data;
  logic [1:0]  xfer_id;
  logic        ack_tog = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk1 = ~clk1;

  s2f_xfer_arbiter #(
    .NREQ(NREQ),
    .DW(DW),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk1(clk1),
    .rstn(rstn),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .xfer_tog(xfer_tog),
    .xfer_data(xfer_data),
    .xfer_id(xfer_id),
    .ack_tog(ack_tog),
    .busy(busy),
    .err(err),
    .err_clr(err_clr)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: channel is free, outstanding, or timed out.
  int         m_mode   = 0;
  int         m_waited = 0;
  int         m_ptr    = 0;
  logic       m_tog    = 1'b0;
  logic [7:0] m_data   = '0;
  logic [1:0] m_id     = '0;
  logic [3:0] m_gnt    = '0;
  logic       m_err    = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_ptr = 0;
    m_tog = 1'b0; m_data = '0; m_id = '0;
    m_gnt = '0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int pick;
    logic [1:0] ix;
    logic set_err;
    set_err = 1'b0;
    m_gnt = '0;
    if (m_mode == 0) begin
      pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        ix = 2'((m_ptr + k) % NREQ);
        if (pick < 0 && req[ix]) pick = int'(ix);
      end
      if (pick >= 0) begin
        m_tog = ~m_tog;
        m_data = 8'(req_data >> (pick * 8));
        m_id = 2'(pick);
        m_gnt = 4'(1 << pick);
        m_ptr = (pick + 1) % NREQ;
        m_mode = 1;
        m_waited = 0;
      end
    end else if (ack_tog == m_tog) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      m_waited++;
      if (TO != 0 && m_waited == TO) begin
        set_err = 1'b1;
        m_mode = 2;
      end
    end
    if (set_err) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  initial forever begin
    @(posedge clk1 or negedge rstn);
    if (!rstn) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk1);
    chk("outputs",
        {15'b0, gnt, xfer_tog, xfer_data, xfer_id, busy, err},
        {15'b0, m_gnt, m_tog, m_data, m_id, (m_mode != 0), m_err});
  end

  // Fast-domain echo: returns the toggle echo_lat cycles after it flips.
  int   echo_lat  = 0;
  int   kick_cnt  = 0;
  int   kick_done = 0;
  logic seen      = 1'b0;
  int   pend      = 0;

  initial forever begin
    @(negedge clk1);
    if (!rstn) begin
      ack_tog = 1'b0; seen = 1'b0; pend = 0;
    end else begin
      if (xfer_tog !== seen) begin
        seen = xfer_tog;
        pend = echo_lat;
      end
      if (kick_cnt != kick_done) begin
        kick_done = kick_cnt;
        pend = 1;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) ack_tog = seen;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int lim);
    int c;
    c = 0;
    while (busy && c < lim) begin
      @(negedge clk1);
      c++;
    end
    chk("idle_wait", busy, 0);
  endtask

  int bcnt, c, k, g2, idle_at, bad_oh, gap_bad;
  logic prev_busy;
  int order[$];
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    rstn = 1'b0; req = '0; req_data = '0; err_clr = 1'b0; echo_lat = 3;
    @(negedge clk1);
    chk("rst_gnt", gnt, 0);
    chk("rst_flags", {busy, err, xfer_tog}, 0);
    chk("rst_data", {xfer_id, xfer_data}, 0);
    #2 rstn = 1'b1;

    // single request, echo after 3 cycles
    @(negedge clk1);
    req_data = 32'h0000_A500; req = 4'b0010;
    @(negedge clk1);
    req = '0;
    chk("s1_gnt", gnt, 4'b0010);
    chk("s1_tog", xfer_tog, 1);
    chk("s1_data", xfer_data, 8'hA5);
    chk("s1_id", xfer_id, 1);
    bcnt = 0; c = 0;
    while (busy && c < 50) begin
      bcnt++;
      @(negedge clk1);
      c++;
    end
    chk("s1_busy_len", bcnt, 3);

    // all four requesting, after a fresh reset
    #2 rstn = 1'b0;
    @(negedge clk1);
    #2 rstn = 1'b1;
    @(negedge clk1);
    echo_lat = 2; req_data = 32'h4433_2211; req = 4'hF;
    prev_busy = busy; bad_oh = 0; gap_bad = 0; c = 0;
    while (order.size() < 5 && c < 100) begin
      @(negedge clk1);
      c++;
      if (gnt != 0) begin
        order.push_back(oh_idx(gnt));
        if (!$onehot(gnt)) bad_oh++;
        if (prev_busy) gap_bad++;
      end
      prev_busy = busy;
    end
    req = '0;
    chk("s2_count", order.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("s2_order%0d", i),
          (i < order.size()) ? order[i] : -1, exp_ord[i]);
    chk("s2_onehot", bad_oh, 0);
    chk("s2_gap", gap_bad, 0);
    wait_idle(10);

    // timeout with no echo, late echo, then err_clr
    echo_lat = 0;
    req_data = 32'h0000_003C; req = 4'b0001;
    @(negedge clk1);
    req = '0;
    chk("s3_gnt", gnt, 4'b0001);
    k = 0;
    while (!err && k < 40) begin
      @(negedge clk1);
      k++;
    end
    chk("s3_to_cycles", k, 15);
    chk("s3_busy", busy, 1);
    repeat (5) @(negedge clk1);
    chk("s3_hold", {busy, err}, 2'b11);
    @(posedge clk1);
    #1 kick_cnt++;
    wait_idle(10);
    chk("s3_err_kept", err, 1);
    @(negedge clk1);
    err_clr = 1'b1;
    @(negedge clk1);
    err_clr = 1'b0;
    chk("s3_err_clr", err, 0);
    echo_lat = 2; req_data = 32'h0077_0000; req = 4'b0100;
    @(negedge clk1);
    req = '0;
    chk("s3_next_gnt", gnt, 4'b0100);
    wait_idle(10);
    chk("s3_next_err", err, 0);

    // echo lands in the same cycle as the timeout
    echo_lat = 15; req_data = 32'hC300_0000; req = 4'b1000;
    @(negedge clk1);
    req = '0;
    bcnt = 0; c = 0;
    while (busy && c < 40) begin
      bcnt++;
      @(negedge clk1);
      c++;
    end
    chk("s4_busy_len", bcnt, 15);
    chk("s4_no_err", err, 0);

    // withdrawn request gets nothing; held one goes first idle cycle
    echo_lat = 4; req_data = 32'hD4B2_00E1; req = 4'b0001;
    @(negedge clk1);
    req = '0;
    chk("s5_first_gnt", gnt, 4'b0001);
    @(negedge clk1);
    req = 4'b0100;
    @(negedge clk1);
    req = 4'b1000;
    g2 = 0; idle_at = -1; c = 0;
    while (c < 30) begin
      @(negedge clk1);
      c++;
      if (gnt[2]) g2++;
      if (!busy && gnt == 0 && idle_at < 0) idle_at = c;
      if (gnt != 0) break;
    end
    req = '0;
    chk("s5_gnt", gnt, 4'b1000);
    chk("s5_no_g2", g2, 0);
    chk("s5_first_idle", c - idle_at, 1);
    wait_idle(20);

    // asynchronous reset mid-transfer
    echo_lat = 0; req_data = 32'h0000_9600; req = 4'b0010;
    @(negedge clk1);
    req = '0;
    chk("s6_gnt", gnt, 4'b0010);
    repeat (3) @(negedge clk1);
    #2 rstn = 1'b0;
    #1 chk("s6_async", {gnt, xfer_tog, xfer_data, xfer_id, busy, err}, 0);
    @(negedge clk1);
    @(negedge clk1);
    #2 rstn = 1'b1;
    @(negedge clk1);
    echo_lat = 1; req_data = 32'h5B00_0000; req = 4'b1000;
    @(negedge clk1);
    req = '0;
    chk("s6_wrap_gnt", gnt, 4'b1000);
    chk("s6_wrap_id", xfer_id, 3);
    chk("s6_wrap_data", xfer_data, 8'h5B);
    wait_idle(10);

    repeat (2) @(negedge clk1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
